// File: rtl/seven_seg_scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  seven_seg_scan_decoder_if
//  Scan-bus inputs and decoded frame/value outputs of the 7-segment decoder.
//  Revision: 1.0
// ============================================================================
interface seven_seg_scan_decoder_if;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic [31:0] frame_digits;
    logic [7:0]  frame_dp;
    logic        frame_valid;
    logic        frame_error;
    logic [26:0] value;
    logic        value_valid;
    logic        seg_error;
    logic        anode_error;

    modport master (
        output seg, dp, an,
        input  frame_digits, frame_dp, frame_valid, frame_error,
        input  value, value_valid, seg_error, anode_error
    );

    modport slave (
        input  seg, dp, an,
        output frame_digits, frame_dp, frame_valid, frame_error,
        output value, value_valid, seg_error, anode_error
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  seven_seg_scan_decoder
//  Recovers digits from a multiplexed 7-segment scan and converts frames to binary.
//  Revision: 1.0
// ============================================================================
module seven_seg_scan_decoder #(
    parameter int unsigned SETTLE = 2
) (
    input  wire logic               clock,
    input  wire logic               reset,
    seven_seg_scan_decoder_if.slave bus_io
);
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_CONV   = 1'b1;
    localparam logic [3:0] c_SETTLE = 4'(SETTLE);

    logic [15:0] sample_q;
    logic [3:0]  stab_q, stab_d;
    logic [31:0] work_digits_q, work_digits_d;
    logic [7:0]  work_dp_q, work_dp_d;
    logic [7:0]  seen_q, seen_d;
    logic        complete_q, complete_d;
    logic [31:0] frame_digits_q;
    logic [7:0]  frame_dp_q;
    logic        frame_valid_q, frame_error_q, seg_error_q, anode_error_q;
    logic [0:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [26:0] acc_q, acc_d;
    logic [31:0] snap_q, snap_d;
    logic [26:0] value_q, value_d;
    logic        value_valid_q, value_valid_d;

    logic [15:0] w_sample;
    logic [7:0]  w_an_low;
    logic        w_multi_low, w_one_low, w_capture, w_frame_err;
    logic [3:0]  w_code, w_digit;
    logic [26:0] w_step;

    assign w_sample    = {bus_io.an, bus_io.seg, bus_io.dp};
    assign w_an_low    = ~bus_io.an;
    assign w_multi_low = (w_an_low & (w_an_low - 8'd1)) != 8'd0;
    assign w_one_low   = (w_an_low != 8'd0) && !w_multi_low;
    assign w_capture   = (stab_d == c_SETTLE) && w_one_low;

    always_comb begin
        if (stab_q == 4'd0 || w_sample != sample_q) begin
            stab_d = 4'd1;
        end else if (stab_q != 4'hF) begin
            stab_d = stab_q + 4'd1;
        end else begin
            stab_d = stab_q;
        end
    end

    always_comb begin
        case (bus_io.seg)
            7'b1000000: w_code = 4'h0;
            7'b1111001: w_code = 4'h1;
            7'b0100100: w_code = 4'h2;
            7'b0110000: w_code = 4'h3;
            7'b0011001: w_code = 4'h4;
            7'b0010010: w_code = 4'h5;
            7'b0000010: w_code = 4'h6;
            7'b1111000: w_code = 4'h7;
            7'b0000000: w_code = 4'h8;
            7'b0010000: w_code = 4'h9;
            7'b0111111: w_code = 4'hA;
            default:    w_code = 4'hF;
        endcase
    end

    // A capture in the same cycle as frame completion starts the next frame.
    always_comb begin
        work_digits_d = work_digits_q;
        work_dp_d     = work_dp_q;
        seen_d        = complete_q ? 8'h00 : seen_q;
        if (w_capture) begin
            for (int k = 0; k < 8; k++) begin
                if (w_an_low[k]) begin
                    work_digits_d[4*k +: 4] = w_code;
                    work_dp_d[k]            = bus_io.dp;
                    seen_d[k]               = 1'b1;
                end
            end
        end
        complete_d = w_capture && (seen_d == 8'hFF);
    end

    always_comb begin
        w_frame_err = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (work_digits_q[4*k +: 4] == 4'hA || work_digits_q[4*k +: 4] == 4'hF) begin
                w_frame_err = 1'b1;
            end
        end
    end

    assign w_digit = snap_q[{idx_q, 2'b00} +: 4];
    assign w_step  = (acc_q * 27'd10) + {23'd0, w_digit};

    // A newly completed frame always takes priority over a conversion in flight.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        snap_d        = snap_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        if (complete_q) begin
            idx_d   = 3'd7;
            acc_d   = 27'd0;
            state_d = w_frame_err ? c_IDLE : c_CONV;
            if (!w_frame_err) begin
                snap_d = work_digits_q;
            end
        end else if (state_q == c_CONV) begin
            acc_d = w_step;
            idx_d = idx_q - 3'd1;
            if (idx_q == 3'd0) begin
                value_d       = w_step;
                value_valid_d = 1'b1;
                state_d       = c_IDLE;
                idx_d         = 3'd7;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_q       <= 16'd0;
            stab_q         <= 4'd0;
            work_digits_q  <= 32'd0;
            work_dp_q      <= 8'd0;
            seen_q         <= 8'd0;
            complete_q     <= 1'b0;
            frame_digits_q <= 32'd0;
            frame_dp_q     <= 8'd0;
            frame_valid_q  <= 1'b0;
            frame_error_q  <= 1'b0;
            seg_error_q    <= 1'b0;
            anode_error_q  <= 1'b0;
            state_q        <= c_IDLE;
            idx_q          <= 3'd7;
            acc_q          <= 27'd0;
            snap_q         <= 32'd0;
            value_q        <= 27'd0;
            value_valid_q  <= 1'b0;
        end else begin
            sample_q      <= w_sample;
            stab_q        <= stab_d;
            work_digits_q <= work_digits_d;
            work_dp_q     <= work_dp_d;
            seen_q        <= seen_d;
            complete_q    <= complete_d;
            frame_valid_q <= complete_q;
            frame_error_q <= complete_q && w_frame_err;
            if (complete_q) begin
                frame_digits_q <= work_digits_q;
                frame_dp_q     <= work_dp_q;
            end
            seg_error_q   <= w_capture && (w_code == 4'hF);
            anode_error_q <= (stab_d == 4'd1) && w_multi_low;
            state_q       <= state_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            snap_q        <= snap_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
        end
    end

    assign bus_io.frame_digits = frame_digits_q;
    assign bus_io.frame_dp     = frame_dp_q;
    assign bus_io.frame_valid  = frame_valid_q;
    assign bus_io.frame_error  = frame_error_q;
    assign bus_io.value        = value_q;
    assign bus_io.value_valid  = value_valid_q;
    assign bus_io.seg_error    = seg_error_q;
    assign bus_io.anode_error  = anode_error_q;
endmodule
`default_nettype wire
